modn_counter_chain: RTL and testbench

Parametrised cascade of modulo-N up/down counter digits. It generalises the team's fixed 4-bit counter next-state logic to a full registered counter with these features:
- configurable digit width, modulus and digit count;
- direction control, synchronous load and clear;
- wrap or saturate mode;
- carry-out and overflow reporting.

It is used as a display or event counter (default: 4-digit BCD, 0000–9999) and cascades with further instances through `carry_out`.

---
 rtl/modn_counter_chain.sv | 92 +++++++++
 tb/tb_modn_counter_chain.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modn_counter_chain.sv
// Cascaded modulo-N up/down counter digits with load, clear, wrap/saturate
// and carry/overflow reporting. Chains to further instances via carry_out.
module modn_counter_chain #(
  parameter int DIGITS  = 4,
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      up,
  input  logic                      sat,
  input  logic                      clear,
  input  logic                      load,
  input  logic [DIGITS*WIDTH-1:0]   load_val,
  output logic [DIGITS*WIDTH-1:0]   count,
  output logic                      carry_out,
  output logic                      ovf
);

  localparam logic [WIDTH-1:0] DIG_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   DIG_MOD = (WIDTH+1)'(MODULUS);

  logic [DIGITS*WIDTH-1:0] count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic [DIGITS-1:0]       at_max, at_zero;
  logic                    term, cnt_go;

  function automatic logic [WIDTH-1:0] dig_inc(input logic [WIDTH-1:0] d);
    return (d == DIG_MAX) ? '0 : d + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] dig_dec(input logic [WIDTH-1:0] d);
    return (d == '0) ? DIG_MAX : d - 1'b1;
  endfunction

  // Out-of-range load digits collapse to zero so every stored digit is legal.
  function automatic logic [WIDTH-1:0] dig_load(input logic [WIDTH-1:0] d);
    return ({1'b0, d} >= DIG_MOD) ? '0 : d;
  endfunction

  always_comb begin
    at_max  = '0;
    at_zero = '0;
    for (int i = 0; i < DIGITS; i++) begin
      at_max[i]  = (count_q[i*WIDTH +: WIDTH] == DIG_MAX);
      at_zero[i] = (count_q[i*WIDTH +: WIDTH] == '0);
    end
  end

  assign term      = up ? (&at_max) : (&at_zero);
  assign cnt_go    = en & ~clear & ~load;
  assign carry_out = cnt_go & term;

  always_comb begin
    logic ripple;
    count_d = count_q;
    ovf_d   = 1'b0;
    ripple  = 1'b1;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      for (int i = 0; i < DIGITS; i++)
        count_d[i*WIDTH +: WIDTH] = dig_load(load_val[i*WIDTH +: WIDTH]);
    end else if (en) begin
      ovf_d = term;
      // A saturating terminal step only reports; the count itself holds.
      if (!(term && sat)) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (ripple)
            count_d[i*WIDTH +: WIDTH] = up ? dig_inc(count_q[i*WIDTH +: WIDTH])
                                           : dig_dec(count_q[i*WIDTH +: WIDTH]);
          ripple = ripple & (up ? at_max[i] : at_zero[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_modn_counter_chain.sv
// Bench for modn_counter_chain: default BCD instance plus a 2-digit mod-6
// instance, checked against an integer-valued reference model.
module tb_modn_counter_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        en = 0, up = 0, sat = 0, clear = 0, load = 0;
  logic [15:0] load_val = '0;
  logic [15:0] count;
  logic        carry_out, ovf;

  logic        en2 = 0, up2 = 0, sat2 = 0, clear2 = 0, load2 = 0;
  logic [5:0]  load_val2 = '0;
  logic [5:0]  count2;
  logic        carry2, ovf2;

  modn_counter_chain #(.DIGITS(4), .WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat), .clear(clear),
    .load(load), .load_val(load_val), .count(count), .carry_out(carry_out),
    .ovf(ovf));

  modn_counter_chain #(.DIGITS(2), .WIDTH(3), .MODULUS(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .up(up2), .sat(sat2), .clear(clear2),
    .load(load2), .load_val(load_val2), .count(count2), .carry_out(carry2),
    .ovf(ovf2));

  int checks = 0;
  int errors = 0;
  int mv = 0, mv2 = 0;
  bit mo = 0, mo2 = 0;
  logic [31:0] exp32;
  bit expc;

  // Count is modelled as a single integer in base MODULUS.
  function automatic logic [31:0] pack(input int v, input int m, input int d, input int w);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      r = r | (32'(x % m) << (i * w));
      x = x / m;
    end
    return r;
  endfunction

  function automatic int unpack_load(input logic [31:0] lv, input int m, input int d, input int w);
    int v, p, dig;
    v = 0;
    p = 1;
    for (int i = 0; i < d; i++) begin
      dig = int'((lv >> (i * w)) & ((32'd1 << w) - 1));
      if (dig >= m) dig = 0;
      v = v + dig * p;
      p = p * m;
    end
    return v;
  endfunction

  function automatic int model_next(input int val, input bit c, input bit l, input bit e,
                                    input bit u, input bit s, input logic [31:0] lv,
                                    input int m, input int d, input int w, output bit ov);
    int top;
    top = 1;
    for (int i = 0; i < d; i++) top = top * m;
    top = top - 1;
    ov = 0;
    if (c) return 0;
    if (l) return unpack_load(lv, m, d, w);
    if (!e) return val;
    if (u) begin
      if (val == top) begin ov = 1; return s ? val : 0; end
      return val + 1;
    end
    if (val == 0) begin ov = 1; return s ? val : top; end
    return val - 1;
  endfunction

  function automatic bit carry_ref(input int v, input bit e, input bit c, input bit l,
                                   input bit u, input int top);
    return e & ~c & ~l & (u ? (v == top) : (v == 0));
  endfunction

  task automatic tick();
    int n1, n2;
    bit o1, o2;
    n1 = model_next(mv, clear, load, en, up, sat, 32'(load_val), 10, 4, 4, o1);
    n2 = model_next(mv2, clear2, load2, en2, up2, sat2, 32'(load_val2), 6, 2, 3, o2);
    @(posedge clk); #1;
    mv = n1; mo = o1; mv2 = n2; mo2 = o2;
  endtask

  task automatic idle();
    en = 0; up = 0; sat = 0; clear = 0; load = 0; load_val = '0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if (count !== 16'h0000 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_init count=%h ovf=%b exp count=0000 ovf=0", count, ovf);
    end
    rst_n = 1; mv = 0; mo = 0; mv2 = 0; mo2 = 0;
    load = 1; load_val = 16'h0436; tick();
    load = 0; en = 1; up = 1; tick();
    checks++;
    if (count !== 16'h0437) begin
      errors++; $display("FAIL reset_precount count=%h exp=0437", count);
    end
    #2 rst_n = 0; #1;
    mv = 0; mo = 0; mv2 = 0; mo2 = 0;
    checks++;
    if (count !== 16'h0000 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_async count=%h ovf=%b exp count=0000 ovf=0", count, ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (count !== 16'h0000) begin
      errors++; $display("FAIL reset_hold count=%h exp=0000", count);
    end
    #2 rst_n = 1;
    tick();
    checks++;
    if (count !== 16'h0001 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_resume count=%h ovf=%b exp count=0001 ovf=0", count, ovf);
    end
    idle();
  endtask

  task automatic test_wrap_up();
    load = 1; load_val = 16'h9998; tick();
    load = 0; en = 1; up = 1; sat = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      expc = carry_ref(mv, en, clear, load, up, 9999);
      checks++;
      if (carry_out !== expc) begin
        errors++; $display("FAIL wrap_up_carry step=%0d got=%b exp=%b", k, carry_out, expc);
      end
      tick();
      exp32 = pack(mv, 10, 4, 4);
      checks++;
      if (count !== exp32[15:0] || ovf !== mo) begin
        errors++; $display("FAIL wrap_up step=%0d count=%h ovf=%b exp count=%h ovf=%b",
                           k, count, ovf, exp32[15:0], mo);
      end
    end
    idle();
  endtask

  task automatic test_wrap_down();
    load = 1; load_val = 16'h1000; tick();
    load = 0; en = 1; up = 0; sat = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      exp32 = pack(mv, 10, 4, 4);
      checks++;
      if (count !== exp32[15:0] || ovf !== mo) begin
        errors++; $display("FAIL borrow step=%0d count=%h ovf=%b exp count=%h ovf=%b",
                           k, count, ovf, exp32[15:0], mo);
      end
    end
    en = 0; load = 1; load_val = 16'h0000; tick();
    load = 0; en = 1; up = 0; #1;
    checks++;
    if (carry_out !== 1'b1) begin
      errors++; $display("FAIL wrap_down_carry got=%b exp=1", carry_out);
    end
    tick();
    checks++;
    if (count !== 16'h9999 || ovf !== 1'b1 || mv != 9999) begin
      errors++; $display("FAIL wrap_down count=%h ovf=%b exp count=9999 ovf=1", count, ovf);
    end
    idle();
  endtask

  task automatic test_saturate();
    load = 1; load_val = 16'h9999; tick();
    load = 0; sat = 1; up = 1; en = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp32 = pack(mv, 10, 4, 4);
      checks++;
      if (count !== exp32[15:0] || ovf !== mo) begin
        errors++; $display("FAIL sat_hold step=%0d count=%h ovf=%b exp count=%h ovf=%b",
                           k, count, ovf, exp32[15:0], mo);
      end
    end
    up = 0; tick();
    checks++;
    if (count !== 16'h9998 || ovf !== 1'b0) begin
      errors++; $display("FAIL sat_reverse count=%h ovf=%b exp count=9998 ovf=0", count, ovf);
    end
    idle();
  endtask

  task automatic test_load_priority();
    load = 1; load_val = 16'h00A5; tick();
    checks++;
    if (count !== 16'h0005) begin
      errors++; $display("FAIL load_range count=%h exp=0005", count);
    end
    load_val = 16'h3B7C; tick();
    exp32 = pack(mv, 10, 4, 4);
    checks++;
    if (count !== exp32[15:0]) begin
      errors++; $display("FAIL load_range2 count=%h exp=%h", count, exp32[15:0]);
    end
    clear = 1; load_val = 16'h1234; tick();
    checks++;
    if (count !== 16'h0000 || ovf !== 1'b0) begin
      errors++; $display("FAIL clear_over_load count=%h exp=0000", count);
    end
    clear = 0; load_val = 16'h9999; tick();
    en = 1; up = 1; load_val = 16'h1234; #1;
    checks++;
    if (carry_out !== 1'b0) begin
      errors++; $display("FAIL load_blocks_carry got=%b exp=0", carry_out);
    end
    tick();
    checks++;
    if (count !== 16'h1234 || ovf !== 1'b0) begin
      errors++; $display("FAIL load_over_en count=%h ovf=%b exp count=1234 ovf=0", count, ovf);
    end
    idle();
  endtask

  task automatic test_random();
    logic [15:0] picks [5];
    picks[0] = 16'h9999; picks[1] = 16'h0000; picks[2] = 16'h9998;
    picks[3] = 16'h0001; picks[4] = 16'h0999;
    for (int k = 0; k < 400; k++) begin
      clear = ($urandom % 25) == 0;
      load  = ($urandom % 12) == 0;
      en    = ($urandom % 4) != 0;
      sat   = ($urandom % 3) == 0;
      if (($urandom % 8) == 0) up = ~up;
      load_val = (($urandom % 2) == 0) ? 16'($urandom) : picks[$urandom % 5];
      #1;
      expc = carry_ref(mv, en, clear, load, up, 9999);
      checks++;
      if (carry_out !== expc) begin
        errors++; $display("FAIL rand_carry k=%0d got=%b exp=%b", k, carry_out, expc);
      end
      tick();
      exp32 = pack(mv, 10, 4, 4);
      checks++;
      if (count !== exp32[15:0] || ovf !== mo) begin
        errors++; $display("FAIL rand k=%0d count=%h ovf=%b exp count=%h ovf=%b",
                           k, count, ovf, exp32[15:0], mo);
      end
    end
    idle();
  endtask

  task automatic test_param_sweep();
    int pulses;
    pulses = 0;
    clear2 = 1; tick();
    clear2 = 0; en2 = 1; up2 = 1; sat2 = 0;
    for (int k = 1; k <= 36; k++) begin
      #1;
      expc = carry_ref(mv2, en2, clear2, load2, up2, 35);
      checks++;
      if (carry2 !== expc) begin
        errors++; $display("FAIL sweep_carry k=%0d got=%b exp=%b", k, carry2, expc);
      end
      tick();
      exp32 = pack(mv2, 6, 2, 3);
      if (ovf2 === 1'b1) pulses++;
      checks++;
      if (count2 !== exp32[5:0] || ovf2 !== mo2) begin
        errors++; $display("FAIL sweep k=%0d count=%o ovf=%b exp count=%o ovf=%b",
                           k, count2, ovf2, exp32[5:0], mo2);
      end
    end
    checks++;
    if (pulses != 1 || count2 !== 6'o00) begin
      errors++; $display("FAIL sweep_end pulses=%0d count=%o exp pulses=1 count=00", pulses, count2);
    end
    en2 = 0; up2 = 0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_priority();
    test_param_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
